fetch_queue: RTL

//   Instruction fetch queue between the IF stage and the ID stage of the MIPS pipeline.
//   - Accepts {PC, Instruction} pairs from IF through a valid/ready handshake.
//   - Buffers up to DEPTH pairs and delivers them to ID in program order.
//   - Back-pressures IF when full. IF holds its PC while in_ready=0.
//   - Discards all buffered fetches on a branch-taken flush.

---
 rtl/fetch_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue between the IF and ID stages. It buffers up to
//   DEPTH {PC, instruction} pairs and hands them to ID in program order. When
//   the queue is full it back-pressures IF. A branch-taken flush discards
//   every buffered fetch.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
//   both 1 in the cycle before that edge. The sender holds its payload stable
//   while valid=1 and ready=0. in_ready and out_valid are derived from
//   registered occupancy only. Neither has a combinational path from
//   in_valid, out_ready or flush.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst        in   asynchronous, active-low reset
//   in_valid   in   IF presents a valid pair
//   in_pc      in   PC of the fetched instruction
//   in_instr   in   fetched instruction
//   in_ready   out  queue can accept a pair this cycle (count != DEPTH)
//   flush      in   branch taken downstream; empty the queue at the next edge
//   out_valid  out  head entry is valid for ID (count != 0)
//   out_pc     out  PC of the head entry, 0 when empty
//   out_instr  out  instruction of the head entry, 0 when empty
//   out_ready  in   ID consumes the head this cycle
//   count      out  number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);

    // Flush masks both transfers, so it wins over any same-cycle traffic.
    assign w_push = in_valid  & w_in_ready  & ~flush;
    assign w_pop  = w_out_valid & out_ready & ~flush;

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // on their own. The count tells full from empty when the pointers match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is not reset. Stale contents are never visible because
    // the outputs are forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_pc    = w_out_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign out_instr = w_out_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign count     = r_count;

endmodule
